// File: rtl/beep_sequencer_module_if.sv
// Play-request / FIFO-write bundle between a controller, the sequencer and the beep FIFO.
// repeat_num exists only when BEEP_SEQ_REPEAT_EN is defined.
interface beep_sequencer_module_if;
  logic       play_req;
  logic [1:0] pattern_sel;
  logic       full_sig;
  logic       write_req;
  logic [7:0] fifo_write_data;
  logic       busy;
  logic       done_sig;
`ifdef BEEP_SEQ_REPEAT_EN
  logic [2:0] repeat_num;

  modport master (output play_req, pattern_sel, full_sig, repeat_num,
                  input  write_req, fifo_write_data, busy, done_sig);
  modport slave  (input  play_req, pattern_sel, full_sig, repeat_num,
                  output write_req, fifo_write_data, busy, done_sig);
`else
  modport master (output play_req, pattern_sel, full_sig,
                  input  write_req, fifo_write_data, busy, done_sig);
  modport slave  (input  play_req, pattern_sel, full_sig,
                  output write_req, fifo_write_data, busy, done_sig);
`endif
endinterface

// File: rtl/beep_sequencer_module.sv
// Expands a one-cycle play request into beep command bytes; first write 2 cycles after acceptance,
// stalls indefinitely on full_sig. BEEP_SEQ_REPEAT_EN adds repeat_num (extra passes).
module beep_sequencer_module (
  input logic                    clk,
  input logic                    rst_n,
  beep_sequencer_module_if.slave bus
);
  localparam logic [7:0] SHORT_CODE = 8'h1B;
  localparam logic [7:0] LONG_CODE  = 8'h2B;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t     state;
  logic [1:0] pat;
  logic [3:0] index;
  logic [3:0] remaining;
  logic [7:0] rom_data;
  logic [3:0] pat_offset;
  logic [3:0] pat_length;
`ifdef BEEP_SEQ_REPEAT_EN
  logic [2:0] passes_left;
`endif

  // Patterns packed back to back: 0 @0 "S", 1 @1 SOS, 2 @10 "L", 3 @11 "SL"
  always_comb begin
    case (index)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd11: rom_data = SHORT_CODE;
      4'd4, 4'd5, 4'd6, 4'd10, 4'd12:                  rom_data = LONG_CODE;
      default:                                          rom_data = 8'h00;
    endcase
  end

  always_comb begin
    case (pat)
      2'd0:    begin pat_offset = 4'd0;  pat_length = 4'd1; end
      2'd1:    begin pat_offset = 4'd1;  pat_length = 4'd9; end
      2'd2:    begin pat_offset = 4'd10; pat_length = 4'd1; end
      default: begin pat_offset = 4'd11; pat_length = 4'd2; end
    endcase
  end

  // Write gating is combinational so a byte is never pushed into a full FIFO.
  assign bus.write_req       = (state == SEND) && !bus.full_sig;
  assign bus.fifo_write_data = (state == SEND) ? rom_data : 8'h00;
  assign bus.busy            = (state != IDLE);
  assign bus.done_sig        = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pat         <= 2'd0;
      index       <= 4'd0;
      remaining   <= 4'd0;
`ifdef BEEP_SEQ_REPEAT_EN
      passes_left <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.play_req) begin
            pat         <= bus.pattern_sel;
`ifdef BEEP_SEQ_REPEAT_EN
            passes_left <= bus.repeat_num;
`endif
            state       <= LOAD;
          end
        end
        LOAD: begin
          index     <= pat_offset;
          remaining <= pat_length;
          state     <= SEND;
        end
        SEND: begin
          if (bus.write_req) begin
            index     <= index + 4'd1;
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
`ifdef BEEP_SEQ_REPEAT_EN
              if (passes_left != 3'd0) begin
                passes_left <= passes_left - 3'd1;
                state       <= LOAD;
              end else begin
                state <= DONE;
              end
`else
              state <= DONE;
`endif
            end
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_beep_sequencer_module.sv
// Directed + randomized bench; an event-scheduling model predicts every cycle's outputs.
module tb_beep_sequencer_module;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  beep_sequencer_module_if bus ();
  beep_sequencer_module dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: queue of bytes still to write, bit 8 marks the last byte of a pass.
  string      pats[4] = '{"S", "SSSLLLSSS", "L", "SL"};
  logic [8:0] exp_q[$];
  bit         m_active = 0;
  int         m_elig = 0, m_done = -1, m_idle = -1;
  int         n_wr = 0, n_done = 0, last_wr_cyc = 0, last_done_cyc = 0;
  bit         sending, exp_wr;
  logic [7:0] exp_dat;
  logic [8:0] e;
  int         passes, p;
  byte        ch;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0;
      exp_q.delete();
      m_done = -1;
      m_idle = -1;
      chk("rst_write_req", bus.write_req, 0);
      chk("rst_data", bus.fifo_write_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done_sig, 0);
    end else begin
      if (m_active && cyc == m_idle) m_active = 0;
      sending = m_active && exp_q.size() > 0 && cyc >= m_elig;
      exp_wr  = sending && !bus.full_sig;
      exp_dat = sending ? exp_q[0][7:0] : 8'h00;
      chk("busy", bus.busy, m_active);
      chk("write_req", bus.write_req, exp_wr);
      chk("data", bus.fifo_write_data, exp_dat);
      chk("done_sig", bus.done_sig, cyc == m_done);
      if (bus.write_req) begin n_wr++; last_wr_cyc = cyc; end
      if (bus.done_sig) begin n_done++; last_done_cyc = cyc; end
      if (exp_wr) begin
        e = exp_q.pop_front();
        if (exp_q.size() == 0) begin
          m_done = cyc + 1;
          m_idle = cyc + 2;
        end else begin
          m_elig = e[8] ? cyc + 2 : cyc + 1;
        end
      end
      if (!m_active && bus.play_req) begin
        passes = 1;
`ifdef BEEP_SEQ_REPEAT_EN
        passes = int'(bus.repeat_num) + 1;
`endif
        p = int'(bus.pattern_sel);
        for (int r = 0; r < passes; r++)
          for (int i = 0; i < pats[p].len(); i++) begin
            ch = pats[p][i];
            exp_q.push_back({(i == pats[p].len() - 1), (ch == "S") ? 8'h1B : 8'h2B});
          end
        m_active = 1;
        m_elig   = cyc + 2;
        m_done   = -1;
        m_idle   = -1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic play(input int pt, input int rep);
    bus.play_req    = 1'b1;
    bus.pattern_sel = pt[1:0];
`ifdef BEEP_SEQ_REPEAT_EN
    bus.repeat_num  = rep[2:0];
`endif
    if (rep < 0) $display("negative repeat");
    step();
    bus.play_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (bus.busy && k < 300) begin step(); k++; end
    chk({tag, "_timeout"}, bus.busy, 0);
  endtask

  int t, w0, d0, k;

  initial begin
    bus.play_req    = 1'b0;
    bus.pattern_sel = 2'd0;
    bus.full_sig    = 1'b0;
`ifdef BEEP_SEQ_REPEAT_EN
    bus.repeat_num  = 3'd0;
`endif
    repeat (3) step();
    chk("reset_busy", bus.busy, 0);
    chk("reset_write_req", bus.write_req, 0);
    rst_n = 1'b1;
    step();

    // Pattern 0: single short beep
    w0 = n_wr; d0 = n_done; t = cyc;
    play(0, 0);
    wait_idle("p0");
    chk("p0_writes", n_wr - w0, 1);
    chk("p0_dones", n_done - d0, 1);
    chk("p0_write_cycle", last_wr_cyc - t, 2);
    chk("p0_done_cycle", last_done_cyc - t, 3);

    // SOS without stall, started in the first idle cycle
    w0 = n_wr; d0 = n_done; t = cyc;
    play(1, 0);
    wait_idle("sos");
    chk("sos_writes", n_wr - w0, 9);
    chk("sos_dones", n_done - d0, 1);
    chk("sos_done_cycle", last_done_cyc - t, 11);

    // Pattern 3 with full_sig high for the first 5 SEND cycles
    w0 = n_wr; d0 = n_done; t = cyc;
    play(3, 0);
    step();
    bus.full_sig = 1'b1;
    repeat (5) step();
    bus.full_sig = 1'b0;
    wait_idle("stall");
    chk("stall_writes", n_wr - w0, 2);
    chk("stall_done_cycle", last_done_cyc - t, 9);

    // Re-requests during SEND and during DONE are ignored
    w0 = n_wr; d0 = n_done; t = cyc;
    play(1, 0);
    repeat (2) step();
    play(2, 0);
    k = 0;
    while (cyc < t + 11 && k < 50) begin step(); k++; end
    chk("ignore_in_done_state", bus.done_sig, 1);
    play(0, 0);
    wait_idle("ignore");
    repeat (3) step();
    chk("ignore_writes", n_wr - w0, 9);
    chk("ignore_dones", n_done - d0, 1);
    chk("ignore_stays_idle", bus.busy, 0);

    // Reset in the middle of SOS, then pattern 2
    w0 = n_wr; d0 = n_done;
    play(1, 0);
    k = 0;
    while (n_wr - w0 < 4 && k < 50) begin step(); k++; end
    rst_n = 1'b0;
    #1;
    chk("midrst_write_req", bus.write_req, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done_sig, 0);
    chk("midrst_writes", n_wr - w0, 4);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    w0 = n_wr; d0 = n_done;
    play(2, 0);
    wait_idle("after_rst");
    chk("after_rst_writes", n_wr - w0, 1);
    chk("after_rst_dones", n_done - d0, 1);

`ifdef BEEP_SEQ_REPEAT_EN
    w0 = n_wr; d0 = n_done; t = cyc;
    play(3, 2);
    wait_idle("repeat");
    chk("repeat_writes", n_wr - w0, 6);
    chk("repeat_dones", n_done - d0, 1);
    chk("repeat_done_cycle", last_done_cyc - t, 10);
`endif

    // Random traffic: requests, patterns, repeats, backpressure and rare resets
    for (int i = 0; i < 1500; i++) begin
      bus.full_sig    = ($urandom_range(0, 3) == 0);
      bus.play_req    = ($urandom_range(0, 7) == 0);
      bus.pattern_sel = 2'($urandom_range(0, 3));
`ifdef BEEP_SEQ_REPEAT_EN
      bus.repeat_num  = 3'($urandom_range(0, 7));
`endif
      if ($urandom_range(0, 299) == 0) begin
        bus.play_req = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end
    bus.play_req = 1'b0;
    bus.full_sig = 1'b0;
    wait_idle("random_drain");
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/beep_sequencer_module.md
# beep_sequencer_module

Pattern sequencer that sits directly upstream of the beep interface. It takes a one-cycle play request with a pattern select and expands it into a fixed sequence of beep command bytes. Those bytes are written into the interface's command FIFO through its `write_req`/`fifo_write_data` port, with flow control on `full_sig`. It gives a key or host controller a single-pulse way to start multi-beep patterns such as SOS.

## Interface
- `SHORT_CODE`, 8'h1B, command byte for a short beep
- `LONG_CODE`, 8'h2B, command byte for a long beep
- `clk` in 1: system clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `play_req` in 1: single-cycle start request, sampled only in IDLE
- `pattern_sel` in 2: pattern to play, latched with `play_req`
- `full_sig` in 1: FIFO full from the beep interface
- `write_req` out 1: FIFO write enable, one byte per high cycle
- `fifo_write_data` out 8: command byte, valid while `write_req`=1
- `busy` out 1: high from acceptance of `play_req` until the return to IDLE
- `done_sig` out 1: one-cycle pulse after the last byte of a play is written
- `repeat_num` in 3: present only with `BEEP_SEQ_REPEAT_EN`; the number of extra repeats

## Operation
- Pattern ROM: 13 entries, 4-bit index, each entry SHORT_CODE (S) or LONG_CODE (L).
  - Pattern 0: offset 0, length 1: S
  - Pattern 1: offset 1, length 9: S S S L L L S S S (SOS)
  - Pattern 2: offset 10, length 1: L
  - Pattern 3: offset 11, length 2: S L
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE, `play_req`=1: latch `pattern_sel` → LOAD. Otherwise stay in IDLE.
- LOAD: index ← pattern offset; remaining ← pattern length → SEND.
- SEND:
  - `write_req` = (state==SEND) && !`full_sig`. This term is combinational, so no write is ever issued while full.
  - Each cycle with `write_req`=1: index +1, remaining −1.
  - When the last byte is written → DONE (or → LOAD, see Configuration).
  - While `full_sig`=1: hold index and data, no write, unbounded stall.
- DONE: `done_sig`=1 for exactly one cycle → IDLE.
- `fifo_write_data` = ROM[index] in SEND, 8'h00 in all other states.
- `busy` = (state != IDLE).
- `play_req` outside IDLE is ignored, with no queuing. This includes the DONE cycle.
- A `pattern_sel` change after latching has no effect on the current play.
- Reset, including mid-pattern: all state returns to reset values immediately. Bytes already written stay in the FIFO; there is no partial rollback.

## Timing
- Reset values: `write_req`=0, `fifo_write_data`=8'h00, `busy`=0, `done_sig`=0, state=IDLE, index=0, remaining=0.
- `play_req` sampled at edge N, with no stall:
  - LOAD in cycle N+1
  - first `write_req` in cycle N+2
  - a pattern of length K writes in cycles N+2 … N+K+1
  - `done_sig` high in cycle N+K+2
  - IDLE (`busy`=0) from cycle N+K+3
- Each cycle of `full_sig`=1 during SEND delays all later events by one cycle.
- `full_sig` going high in the same cycle as a pending write suppresses that write. The same byte is offered again in the next cycle that `full_sig`=0.
- Earliest next acceptance: a `play_req` sampled at the edge that ends the first IDLE cycle.

## Configuration
- Macro: `BEEP_SEQ_REPEAT_EN`.
- Defined:
  - The `repeat_num[2:0]` port exists and is latched with `play_req`.
  - After the last byte of each pass, if passes remaining > 0: decrement, → LOAD (one bubble cycle, no write).
  - Total passes = `repeat_num`+1, up to 8. `done_sig` pulses once, after the final pass.
- Undefined: the port is absent, and every play is a single pass.

## Test plan
- Pattern 0, `full_sig`=0, `play_req` at edge 10: `write_req` in cycle 12 only, data 8'h1B, `done_sig` in cycle 13, `busy` in cycles 11–13.
- Pattern 1, no stall: 9 consecutive writes 1B,1B,1B,2B,2B,2B,1B,1B,1B, then a single `done_sig` 1 cycle after the last write.
- Pattern 3, with `full_sig` held high for 5 cycles from the first SEND cycle: no write while full. Then 1B, then 2B on the following cycles, and `done_sig` is 5 cycles later than the no-stall case.
- `play_req` re-pulsed during SEND and during DONE: ignored, with exactly 1 `done_sig` and the byte count of one pattern.
- `rst_n` low after 4 SOS bytes: `write_req`, `busy` and `done_sig` drop to 0 immediately. After release, pattern 2 plays 8'h2B correctly.
- With `BEEP_SEQ_REPEAT_EN`, pattern 3, `repeat_num`=2: 1B,2B, bubble, 1B,2B, bubble, 1B,2B, then one `done_sig`.
